// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  // One buffered frame: four hex nibbles plus one decimal point per digit
  typedef struct packed {
    logic [DATA_W-1:0]     value;
    logic [NUM_DIGITS-1:0] dp;
  } frame_t;

  // Active-high segment patterns, bit order g..a, indexed by nibble value
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high seven-segment pattern (g..a); purely combinational.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] pattern_c
);

  assign pattern_c = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DWELL          = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  frame_t           shadow;
  frame_t           display;

  frame_t                din_frame_c;
  logic [NIB_W-1:0]      nib_c;
  logic [SEG_W-1:0]      pattern_c;
  logic                  lzb_c;
  logic [NUM_DIGITS-1:0] an_on_c;

  assign din_frame_c = {din, dp_in};
  assign nib_c       = display.value[{idx, 2'b00} +: NIB_W];
  assign an_on_c     = NUM_DIGITS'(1) << idx;

  seg7_hex_decode u_hex_decode (
    .nib       (nib_c),
    .pattern_c (pattern_c)
  );

  // Digit idx is a leading zero when it and every nibble above it are zero
`ifdef SEG7_LZB_EN
  assign lzb_c = (idx != '0) && ((display.value >> {idx, 2'b00}) == '0);
`else
  assign lzb_c = 1'b0;
`endif

  // Scan FSM; outputs are loaded for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      display     <= '0;
      frame_start <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
    end else begin
      frame_start <= 1'b0;
      if (din_valid) begin
        shadow <= din_frame_c;
      end
      case (state)
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYC - 1)) begin
            state <= SHOW;
            cnt   <= '0;
            an    <= an_on_c ^ AN_OFF;
            seg   <= (pattern_c & {SEG_W{~lzb_c}}) ^ SEG_OFF;
            dp    <= display.dp[idx] ^ DP_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == CNT_W'(DWELL - 1)) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= idx + IDX_W'(1);
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= DP_OFF;
            // Frame boundary: a strobe on this very edge beats the shadow copy
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
              display     <= din_valid ? din_frame_c : shadow;
              frame_start <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DWELL=4, BLANK_CYC=2 (frame = 24 cycles).
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } frame_exp_t;

  typedef struct {
    logic [15:0]     din;
    logic [3:0]      dpv;
    int              at;
    logic [3:0][6:0] seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_valid;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  frame_exp_t cur;
  frame_exp_t zero_exp;
  frame_exp_t q[$];
  vec_t       vecs[5];

  seg7_scan_driver #(
    .DWELL          (4),
    .BLANK_CYC      (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .dp_in       (dp_in),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d t=%0t: got %h expected %h", name, cyc, $time, act, exp);
    end
  endtask

  // Advance one clock, then compare all outputs against the expected scan position
  task automatic step();
    int         pos;
    int         dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    @(posedge clk);
    #1;
    cyc++;
    pos  = cyc % 6;
    dig  = (cyc / 6) % 4;
    e_fs = (cyc % 24 == 0);
    if (pos < 2) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << dig);
      e_seg = cur.seg[dig];
      e_dp  = ~cur.dp[dig];
    end
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
    check("frame_start", 16'(frame_start), 16'(e_fs));
    if (e_fs && q.size() > 0) begin
      cur = q[q.size()-1];
      q.delete();
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_pos(input int p);
    while (cyc % 24 != p) step();
  endtask

  task automatic to_commit();
    do step(); while (cyc % 24 != 0);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0][6:0] s);
    frame_exp_t e;
    e.seg = s;
    e.dp  = p;
    q.push_back(e);
    din       = d;
    dp_in     = p;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din       = 16'($urandom);
    dp_in     = 4'($urandom);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, 16'(an), 16'hF);
    check({tag, "_seg"}, 16'(seg), 16'h7F);
    check({tag, "_dp"}, 16'(dp), 16'h1);
    check({tag, "_fs"}, 16'(frame_start), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][6:0] five_seg;

    vecs[0].din = 16'h12AF; vecs[0].dpv = 4'b0000; vecs[0].at = 3;
    vecs[0].seg = {7'h79, 7'h24, 7'h08, 7'h0E};
    vecs[1].din = 16'h0030; vecs[1].dpv = 4'b0100; vecs[1].at = 7;
    vecs[2].din = 16'h8C5E; vecs[2].dpv = 4'b1001; vecs[2].at = 11;
    vecs[2].seg = {7'h00, 7'h46, 7'h12, 7'h06};
    vecs[3].din = 16'h79BD; vecs[3].dpv = 4'b0000; vecs[3].at = 15;
    vecs[3].seg = {7'h78, 7'h10, 7'h03, 7'h21};
    vecs[4].din = 16'h0046; vecs[4].dpv = 4'b0010; vecs[4].at = 19;
`ifdef SEG7_LZB_EN
    vecs[1].seg   = {7'h7F, 7'h7F, 7'h30, 7'h40};
    vecs[4].seg   = {7'h7F, 7'h7F, 7'h19, 7'h02};
    zero_exp.seg  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    five_seg      = {7'h7F, 7'h7F, 7'h7F, 7'h12};
`else
    vecs[1].seg   = {7'h40, 7'h40, 7'h30, 7'h40};
    vecs[4].seg   = {7'h40, 7'h40, 7'h19, 7'h02};
    zero_exp.seg  = {7'h40, 7'h40, 7'h40, 7'h40};
    five_seg      = {7'h40, 7'h40, 7'h40, 7'h12};
`endif
    zero_exp.dp = 4'b0000;

    rst       = 1'b1;
    din       = 16'h0;
    din_valid = 1'b0;
    dp_in     = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_dark("reset");
    din = 16'hFFFF; din_valid = 1'b1; dp_in = 4'hF;
    @(posedge clk);
    #1;
    check_dark("reset_hold");
    din_valid = 1'b0;

    rst = 1'b0;
    cyc = 0;
    cur = zero_exp;
    run(48);

    // Table of single loads at various points inside a frame
    for (int r = 0; r < 5; r++) begin
      wait_pos(vecs[r].at);
      load(vecs[r].din, vecs[r].dpv, vecs[r].seg);
      to_commit();
      run(24);
    end

    // Two strobes in one frame: only the second is shown
    wait_pos(5);
    load(vecs[2].din, vecs[2].dpv, vecs[2].seg);
    wait_pos(9);
    load(vecs[1].din, vecs[1].dpv, vecs[1].seg);
    to_commit();
    run(24);

    // Strobe landing exactly on the commit edge overrides the pending shadow
    wait_pos(10);
    load(vecs[0].din, vecs[0].dpv, vecs[0].seg);
    wait_pos(23);
    load(16'h0005, 4'b0000, five_seg);
    run(48);

    // Asynchronous reset while digit 2 is lit, with a load still pending
    wait_pos(2);
    load(vecs[2].din, vecs[2].dpv, vecs[2].seg);
    to_commit();
    wait_pos(14);
    load(vecs[3].din, vecs[3].dpv, vecs[3].seg);
    check("digit2_lit", 16'(an), 16'hB);
    #2;
    rst = 1'b1;
    #1;
    check_dark("async_rst");
    @(posedge clk);
    #1;
    check_dark("async_rst_hold");
    rst = 1'b0;
    cyc = 0;
    cur = zero_exp;
    q.delete();
    run(48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
